// File: rtl/mux_4to1_rr_arbiter_pkg.sv
// Shared definitions for the 4-requester round-robin arbiter in front of the
// 4:1 single-bit mux. The optional grant statistics are enabled with the
// MUX_ARB_STATS_EN macro.
package mux_4to1_rr_arbiter_pkg;

    localparam int NUM_REQ      = 4;
    localparam int SEL_W        = 2;
    localparam int MAX_HOLD_DEF = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Pick the first asserted request scanning upward from (last+1) with wrap.
    // The scan runs from lowest to highest priority so the last hit wins; the
    // previous owner (offset 4 == offset 0) is considered last.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req_vec,
                                                 input logic [SEL_W-1:0]   last_owner);
        logic [SEL_W-1:0] idx;
        rr_pick = last_owner;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = last_owner + SEL_W'(k);
            if (req_vec[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/mux_4to1_rr_arbiter_mux.sv
// Shared 4:1 single-bit mux. Purely combinational.
module mux_4to1 (
    input  logic       x0,
    input  logic       x1,
    input  logic       x2,
    input  logic       x3,
    input  logic [1:0] sel,
    output logic       y
);

    // Select one of the four inputs.
    always_comb begin
        case (sel)
            2'd0:    y = x0;
            2'd1:    y = x1;
            2'd2:    y = x2;
            default: y = x3;
        endcase
    end

endmodule

// File: rtl/mux_4to1_rr_arbiter.sv
// Round-robin arbiter owning the select of the shared 4:1 mux. One requester is
// granted at a time for at most MAX_HOLD cycles, with a one-cycle idle bubble
// between owners. Define MUX_ARB_STATS_EN to add per-requester grant counters.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | no owner; arbitrate among asserted requests this cycle
//   ST_GRANT | owner holds the mux; release on req drop or hold limit
module mux_4to1_rr_arbiter
    import mux_4to1_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] data_in,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
`ifdef MUX_ARB_STATS_EN
    output logic [31:0]        grant_cnt,
`endif
    output logic               y
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

    arb_state_t         state, state_n;
    logic [NUM_REQ-1:0] grant_n;
    logic [SEL_W-1:0]   sel_n, last, last_n, win;
    logic               busy_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               mux_y;

    // State and registered outputs; reset returns the pointer to 3 so requester 0 goes first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            grant <= '0;
            sel   <= '0;
            busy  <= 1'b0;
            cnt   <= '0;
            last  <= SEL_W'(NUM_REQ - 1);
        end else begin
            state <= state_n;
            grant <= grant_n;
            sel   <= sel_n;
            busy  <= busy_n;
            cnt   <= cnt_n;
            last  <= last_n;
        end
    end

    // Next-state: arbitrate in IDLE, count hold time and detect release in GRANT.
    always_comb begin
        state_n = state;
        grant_n = grant;
        sel_n   = sel;
        busy_n  = busy;
        cnt_n   = cnt;
        last_n  = last;
        win     = rr_pick(req, last);
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_n = ST_GRANT;
                    grant_n = NUM_REQ'(1) << win;
                    sel_n   = win;
                    busy_n  = 1'b1;
                    cnt_n   = CNT_W'(1);
                    last_n  = win;
                end
            end
            default: begin
                if (!req[sel] || cnt == HOLD_LIM) begin
                    state_n = ST_IDLE;
                    grant_n = '0;
                    busy_n  = 1'b0;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
        endcase
    end

    mux_4to1 u_mux (
        .x0  (data_in[0]),
        .x1  (data_in[1]),
        .x2  (data_in[2]),
        .x3  (data_in[3]),
        .sel (sel),
        .y   (mux_y)
    );

    assign y = busy & mux_y;

`ifdef MUX_ARB_STATS_EN
    // Saturating per-requester grant counters, bumped on each IDLE->GRANT edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else if (state == ST_IDLE && |req) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (win == SEL_W'(i) && grant_cnt[8*i +: 8] != 8'hFF) begin
                    grant_cnt[8*i +: 8] <= grant_cnt[8*i +: 8] + 8'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux_4to1_rr_arbiter.sv
// Scoreboard bench for mux_4to1_rr_arbiter: the driver runs a behavioural model
// at each rising edge and queues the expected outputs; the monitor pops and
// compares at the falling edge.
module tb_mux_4to1_rr_arbiter;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] data_in;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       y;
`ifdef MUX_ARB_STATS_EN
    logic [31:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    mux_4to1_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .grant     (grant),
        .sel       (sel),
        .busy      (busy),
`ifdef MUX_ARB_STATS_EN
        .grant_cnt (grant_cnt),
`endif
        .y         (y)
    );

    typedef struct {
        logic [3:0]  grant;
        logic [1:0]  sel;
        logic        busy;
        logic        y;
        logic [31:0] cnts;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 0;

    // Reference model: owner index (-1 when nobody holds the mux), how long it
    // has held, who was granted last, and the mux select remembered across idles.
    int owner = -1;
    int held  = 0;
    int last_w = 3;
    int m_sel = 0;
    int gcount[4] = '{0, 0, 0, 0};

    function automatic void model_edge(input logic r, input logic [3:0] q);
        if (!r) begin
            owner = -1; held = 0; last_w = 3; m_sel = 0;
            for (int i = 0; i < 4; i++) gcount[i] = 0;
        end else if (owner < 0) begin
            if (q != 4'b0000) begin
                for (int k = 1; k <= 4; k++) begin
                    int c;
                    c = (last_w + k) % 4;
                    if (q[c] && owner < 0) owner = c;
                end
                held = 1; last_w = owner; m_sel = owner;
                if (gcount[owner] < 255) gcount[owner]++;
            end
        end else if (!q[owner] || held == MAX_HOLD) begin
            owner = -1; held = 0;
        end else begin
            held++;
        end
    endfunction

    task automatic cycle(input logic r, input logic [3:0] q, input logic [3:0] d);
        exp_t e;
        @(posedge clk);
        model_edge(rst_n, req);
        #1;
        rst_n = r; req = q; data_in = d;
        e.busy  = (owner >= 0);
        e.grant = e.busy ? (4'b0001 << owner) : 4'b0000;
        e.sel   = 2'(m_sel);
        e.y     = e.busy ? d[m_sel] : 1'b0;
        e.cnts  = {8'(gcount[3]), 8'(gcount[2]), 8'(gcount[1]), 8'(gcount[0])};
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grant", 32'(grant), 32'(e.grant));
                check("sel",   32'(sel),   32'(e.sel));
                check("busy",  32'(busy),  32'(e.busy));
                check("y",     32'(y),     32'(e.y));
`ifdef MUX_ARB_STATS_EN
                check("grant_cnt", grant_cnt, e.cnts);
`endif
            end
        end
    end

    initial begin
        logic [3:0] q, d;
        logic       r;
        rst_n = 1'b0; req = 4'b1111; data_in = 4'b0000;
        // Reset held two cycles with all requests up.
        cycle(1'b0, 4'b1111, 4'b0000);
        cycle(1'b0, 4'b1111, 4'b1111);
        // Round-robin rotation with hold timeouts.
        for (int i = 0; i < 45; i++) cycle(1'b1, 4'b1111, 4'($urandom_range(0, 15)));
        // Single requester held: timeout, bubble, regrant.
        for (int i = 0; i < 22; i++) cycle(1'b1, 4'b0001, 4'b0001);
        cycle(1'b1, 4'b0000, 4'b0000);
        cycle(1'b1, 4'b0000, 4'b0000);
        // Single requester 2, then drop.
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'b0100, 4'b0100);
        cycle(1'b1, 4'b0000, 4'b0100);
        cycle(1'b1, 4'b0000, 4'b0100);
        // Owner 3 with data toggling; lower data bits noise.
        for (int i = 0; i < 10; i++) cycle(1'b1, 4'b1000, {i[0], 3'($urandom_range(0, 7))});
        cycle(1'b1, 4'b0000, 4'b0000);
        cycle(1'b1, 4'b0000, 4'b0000);
        // Owner 1, reset on its third grant cycle, then all requesting.
        cycle(1'b1, 4'b0010, 4'b0010);
        cycle(1'b1, 4'b0010, 4'b0010);
        cycle(1'b1, 4'b0010, 4'b0010);
        cycle(1'b0, 4'b0010, 4'b0010);
        for (int i = 0; i < 6; i++) cycle(1'b1, 4'b1111, 4'b1111);
        // Randomized traffic with sticky requests and rare resets.
        q = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) q = 4'($urandom_range(0, 15));
            d = 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 99) != 0);
            cycle(r, q, d);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_4to1_rr_arbiter.md
Name: mux_4to1_rr_arbiter

Overview:
- Round-robin arbiter that shares the existing 4:1 single-bit mux between four requesters.
- Each requester i presents one data bit on data_in[i] and a request on req[i].
- The arbiter owns the mux select and grants one requester at a time, with a bounded hold time.
- Sits between requester logic and the shared mux instance; the mux output is exported as y.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant (legal range 1..15).
- CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- req  input  4  request vector, bit i = requester i
- data_in  input  4  data bits, bit i routed to mux input x_i
- grant  output  4  one-hot grant, registered; all-zero when idle
- sel  output  2  mux select, registered; index of current owner
- busy  output  1  registered; 1 while any grant is active
- y  output  1  shared mux output; forced 0 when busy=0

Behaviour:
- Reset (rst_n=0 sampled at clk edge): state=IDLE, grant=4'b0000, sel=2'b00, busy=0, hold counter=0, last-owner pointer=3 (so requester 0 has first priority). y=0.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, pick the first asserted req scanning upward from (last+1) mod 4 with wrap-around.
  - Next edge: grant=onehot(winner), sel=winner, busy=1, counter=1, last=winner, state=GRANT.
  - Latency: req sampled at edge N gives grant at edge N+1.
- GRANT, release conditions:
  - The owner's req drops (req[sel]=0), or counter==MAX_HOLD.
  - On release: next edge grant=0, busy=0, counter=0, state=IDLE. sel holds its last value.
  - This gives a mandatory one-cycle idle bubble between owners. A new winner can be granted no earlier than two edges after release is detected.
- GRANT, no release: counter increments by 1 per cycle; grant and sel are unchanged.
- Other requesters' req changes during GRANT are ignored until IDLE.
- Fairness: after a MAX_HOLD release, the expiring owner is the lowest priority in the next arbitration even if its req is still high.
- y = busy ? data_in[sel] : 0. Combinational through the mux, so data may change every cycle while granted.
- Reset mid-GRANT: the next edge returns every output and the pointer to reset values, with no partial release cycle.
- MAX_HOLD=1: every grant lasts exactly one cycle followed by one IDLE cycle.

Optional Feature:
- Macro: MUX_ARB_STATS_EN.
- Defined: adds output grant_cnt (4 x 8 bits, packed 32-bit vector, field i = bits [8i+7:8i]).
  - Each field counts grants issued to requester i, incremented on the IDLE->GRANT edge.
  - Counters saturate at 255 and are cleared by rst_n.
- Undefined: port and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/include file mux_arb_defs.vh:
  - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1
  - NUM_REQ=4, SEL_W=2
  - default MAX_HOLD
- One natural sub-module: instantiate the existing mux_4to1 (x0..x3=data_in[0..3], sel=sel), then gate its y with busy.
- Round-robin pick logic stays as an internal function, not a separate module.

Test Plan:
- Reset: hold rst_n=0 two cycles with req=4'b1111 -> grant=0000, busy=0, sel=00, y=0 throughout; release reset -> next edge grant=0001, sel=00.
- Single requester: req=0100, data_in=0100 -> grant=0100, sel=10, y=1 one edge later; drop req[2] -> next edge grant=0000, busy=0, y=0.
- Round-robin: req=1111 held, MAX_HOLD=2 -> grant sequence 0001,0001,0000,0010,0010,0000,0100,0100,0000,1000,1000,0000,0001.
- Hold timeout: MAX_HOLD=8, req=0001 held only -> grant=0001 for exactly 8 cycles, 1 idle cycle, then 0001 again.
- Data routing: owner 3, data_in toggling 1000/0000 each cycle -> y toggles 1/0 in the same cycles; data_in[0..2] toggles have no effect on y.
- Reset mid-grant: assert rst_n=0 on the 3rd GRANT cycle of owner 1 -> next edge all outputs at reset values; after release, req=1111 grants requester 0 first. With MUX_ARB_STATS_EN defined, all grant_cnt fields read 0.
